// File: rtl/mem_resp_pkg.sv
// Shared definitions for the data-memory responder.
//   state_e : responder FSM states
//   WORD_W  : storage / data word width
//   CNT_W   : latency counter width (LATENCY up to 15)
package mem_resp_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mem_resp_array.sv
// Word storage for the data-memory responder: synchronous write, synchronous read.
// A read of the word being written on the same edge returns the old contents.
// Ports:
//   clk   : clock
//   we    : write enable
//   waddr : write word index
//   wdata : write data
//   raddr : read word index
//   rdata : registered read data (mem[raddr] as seen at the last edge)
module mem_resp_array
    import mem_resp_pkg::*;
#(
    parameter int unsigned WORDS_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [WORDS_LOG2-1:0] waddr,
    input  logic [WORD_W-1:0]     wdata,
    input  logic [WORDS_LOG2-1:0] raddr,
    output logic [WORD_W-1:0]     rdata
);

    logic [WORD_W-1:0] mem [2**WORDS_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle data-memory responder for the CPU load/store port. Accepts one word
// request at a time, performs the access LATENCY cycles later and holds the
// response until the CPU takes it.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake (ready only in IDLE, never in reset)
//   req_wr              : 1 = store, 0 = load
//   req_addr            : byte address, bit 0 ignored, upper bits wrap
//   req_wdata           : store data
//   rsp_valid/rsp_ready : response handshake, response held until taken
//   rsp_wr              : echo of req_wr for the held response
//   rsp_rdata           : load data, or the data written for a store
//   busy                : high in WAIT or RESP
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned WORDS_LOG2 = 10,
    parameter int unsigned LATENCY    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_wr,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [WORDS_LOG2-1:0]   idx_q;
    logic                    wr_q;
    logic [WORD_W-1:0]       wdata_q;
    logic                    rsp_wr_q;
    logic [WORD_W-1:0]       rsp_data_q;

    logic [WORDS_LOG2-1:0]   req_idx;
    logic [WORDS_LOG2-1:0]   acc_idx;
    logic                    acc_wr;
    logic [WORD_W-1:0]       acc_wdata;
    logic                    access;
    logic [WORD_W-1:0]       arr_rdata;
    logic                    unused_addr;

    assign req_idx     = req_addr[WORDS_LOG2:1];
    assign unused_addr = ^{req_addr[ADDR_W-1:WORDS_LOG2+1], req_addr[0]};

    // In IDLE the access operands come straight from the request so LATENCY==1
    // can hit the array on the accept edge; otherwise from the capture registers.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        access    = 1'b0;
        acc_idx   = idx_q;
        acc_wr    = wr_q;
        acc_wdata = wdata_q;
        unique case (state_q)
            IDLE: begin
                acc_idx   = req_idx;
                acc_wr    = req_wr;
                acc_wdata = req_wdata;
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        access  = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    access  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            rsp_wr_q   <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && req_valid) begin
                idx_q   <= req_idx;
                wr_q    <= req_wr;
                wdata_q <= req_wdata;
            end
            if (access) begin
                rsp_wr_q <= acc_wr;
                if (acc_wr) begin
                    rsp_data_q <= acc_wdata;
                end
            end
            // Keep the load result visible after the handshake once the array
            // read port moves on to the next request.
            if (state_q == RESP && rsp_ready && !rsp_wr_q) begin
                rsp_data_q <= arr_rdata;
            end
        end
    end

    // Write is suppressed in reset so an aborted store never commits.
    mem_resp_array #(
        .WORDS_LOG2 (WORDS_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (access && acc_wr && !rst),
        .waddr (acc_idx),
        .wdata (acc_wdata),
        .raddr (acc_idx),
        .rdata (arr_rdata)
    );

    // The array read port keeps re-reading the held index in RESP and nothing
    // writes meanwhile, so its output is stable for the whole response.
    assign req_ready = (state_q == IDLE) && !rst;
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_wr    = rsp_wr_q;
    assign rsp_rdata = (state_q == RESP && !rsp_wr_q) ? arr_rdata : rsp_data_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    // dut4: LATENCY=4, driven by directed transactions
    logic        req_valid_a, req_ready_a, req_wr_a, rsp_valid_a, rsp_ready_a, rsp_wr_a, busy_a;
    logic [15:0] req_addr_a, req_wdata_a, rsp_rdata_a;
    // dut1: LATENCY=1, rsp_ready tied high, streaming
    logic        req_valid_b, req_ready_b, req_wr_b, rsp_valid_b, rsp_ready_b, rsp_wr_b, busy_b;
    logic [15:0] req_addr_b, req_wdata_b, rsp_rdata_b;

    mem_responder #(.ADDR_W(16), .WORDS_LOG2(10), .LATENCY(4)) dut4 (
        .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_wr(req_wr_a), .req_addr(req_addr_a), .req_wdata(req_wdata_a),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a), .rsp_wr(rsp_wr_a),
        .rsp_rdata(rsp_rdata_a), .busy(busy_a)
    );

    mem_responder #(.ADDR_W(16), .WORDS_LOG2(10), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_wr(req_wr_b), .req_addr(req_addr_b), .req_wdata(req_wdata_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_wr(rsp_wr_b),
        .rsp_rdata(rsp_rdata_b), .busy(busy_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one outstanding request, a countdown of edges until the
    // response appears, a held response, and a plain word array.
    logic        m_pend [2];
    int          m_left [2];
    logic        m_rv   [2];
    logic        m_rwr  [2];
    logic [15:0] m_rdata[2];
    int          m_idx  [2];
    logic        m_wr   [2];
    logic [15:0] m_wd   [2];
    logic [15:0] m_mem  [2][1024];

    task automatic do_access(input int i);
        m_pend[i] = 1'b0;
        m_rv[i]   = 1'b1;
        m_rwr[i]  = m_wr[i];
        if (m_wr[i]) begin
            m_mem[i][m_idx[i]] = m_wd[i];
            m_rdata[i]         = m_wd[i];
        end else begin
            m_rdata[i] = m_mem[i][m_idx[i]];
        end
    endtask

    task automatic model_step(input int i, input int lat, input logic v, input logic w,
                              input logic [15:0] a, input logic [15:0] d, input logic rr);
        if (rst) begin
            m_pend[i] = 1'b0; m_rv[i] = 1'b0; m_rdata[i] = 16'h0; m_rwr[i] = 1'b0;
        end else if (m_rv[i]) begin
            if (rr) m_rv[i] = 1'b0;
        end else if (m_pend[i]) begin
            m_left[i]--;
            if (m_left[i] == 0) do_access(i);
        end else if (v) begin
            m_idx[i]  = (int'(a) / 2) % 1024;
            m_wr[i]   = w;
            m_wd[i]   = d;
            m_left[i] = lat - 1;
            m_pend[i] = 1'b1;
            if (m_left[i] == 0) do_access(i);
        end
    endtask

    always @(posedge clk) begin
        if (rst) started = 1'b1;
        model_step(0, 4, req_valid_a, req_wr_a, req_addr_a, req_wdata_a, rsp_ready_a);
        model_step(1, 1, req_valid_b, req_wr_b, req_addr_b, req_wdata_b, rsp_ready_b);
    end

    task automatic cmp_dut(input int i, input logic rdy, input logic rv, input logic rw,
                           input logic [15:0] rd, input logic bsy);
        chk($sformatf("m%0d_req_ready", i), rdy, !rst && !m_pend[i] && !m_rv[i]);
        chk($sformatf("m%0d_rsp_valid", i), rv, m_rv[i]);
        chk($sformatf("m%0d_busy", i), bsy, m_pend[i] || m_rv[i]);
        if (m_rv[i]) begin
            chk($sformatf("m%0d_rsp_wr", i), rw, m_rwr[i]);
            chk($sformatf("m%0d_rsp_rdata", i), rd, m_rdata[i]);
        end
    endtask

    always begin
        @(negedge clk);
        #2;
        if (started) begin
            cmp_dut(0, req_ready_a, rsp_valid_a, rsp_wr_a, rsp_rdata_a, busy_a);
            cmp_dut(1, req_ready_b, rsp_valid_b, rsp_wr_b, rsp_rdata_b, busy_b);
        end
    end

    // One request on dut4; returns the data seen at the first rsp_valid cycle and
    // the number of edges from accept to the first edge at which rsp_valid is high.
    task automatic txn(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                       input int hold, output logic [15:0] data, output logic wr_seen,
                       output int lat);
        int n;
        @(negedge clk);
        req_valid_a = 1'b1; req_wr_a = wr; req_addr_a = addr; req_wdata_a = wdata;
        n = 0;
        while (!req_ready_a && n < 20) begin @(negedge clk); n++; end
        chk("accept_wait", req_ready_a, 1'b1);
        @(negedge clk);
        // Scramble the request bus: captured values must not follow it.
        req_valid_a = 1'b0; req_wr_a = ~wr; req_addr_a = 16'hFFFF; req_wdata_a = 16'h0BAD;
        lat = 1;
        while (!rsp_valid_a && lat < 30) begin @(negedge clk); lat++; end
        chk("rsp_wait", rsp_valid_a, 1'b1);
        data    = rsp_rdata_a;
        wr_seen = rsp_wr_a;
        repeat (hold) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid_a, 1'b1);
            chk("bp_rdata", rsp_rdata_a, data);
            chk("bp_busy", busy_a, 1'b1);
            chk("bp_ready", req_ready_a, 1'b0);
        end
        rsp_ready_a = 1'b1;
        @(negedge clk);
        rsp_ready_a = 1'b0;
    endtask

    initial begin
        logic [15:0] d;
        logic        w;
        int          lat;
        logic        s_wr  [6];
        logic [15:0] s_addr[6];
        logic [15:0] s_wd  [6];
        logic [15:0] s_exp [6];
        int          j, nresp, last, cyc;
        logic        prev;

        s_wr   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        s_addr = '{16'h0100, 16'h0100, 16'h0102, 16'h0103, 16'h0100, 16'h0101};
        s_wd   = '{16'h1111, 16'h0000, 16'h2222, 16'h0000, 16'h3333, 16'h0000};
        s_exp  = '{16'h1111, 16'h1111, 16'h2222, 16'h2222, 16'h3333, 16'h3333};

        // Reset held 2 cycles with requests pending on both DUTs
        rst = 1'b1;
        req_valid_a = 1'b1; req_wr_a = 1'b1; req_addr_a = 16'h0010; req_wdata_a = 16'hDEAD;
        rsp_ready_a = 1'b0;
        req_valid_b = 1'b1; req_wr_b = 1'b1; req_addr_b = 16'h0100; req_wdata_b = 16'hDEAD;
        rsp_ready_b = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready_a, 1'b0);
        chk("rst_rsp_valid", rsp_valid_a, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata_a, 16'h0000);
        chk("rst_rsp_wr", rsp_wr_a, 1'b0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_req_ready_l1", req_ready_b, 1'b0);
        rst = 1'b0; req_valid_a = 1'b0; req_valid_b = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", req_ready_a, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_access", {rsp_valid_a, busy_a, rsp_valid_b}, 3'b000);
        end

        // Store then load, bit 0 of the address ignored
        txn(1'b1, 16'h0010, 16'hBEEF, 0, d, w, lat);
        chk("sw_latency", lat, 4);
        chk("sw_rsp_wr", w, 1'b1);
        chk("sw_rdata", d, 16'hBEEF);
        txn(1'b0, 16'h0011, 16'h0000, 0, d, w, lat);
        chk("lw_latency", lat, 4);
        chk("lw_rsp_wr", w, 1'b0);
        chk("lw_rdata", d, 16'hBEEF);

        // Back-pressure: response held for 6 extra cycles
        txn(1'b0, 16'h0010, 16'h0000, 6, d, w, lat);
        chk("bp_data", d, 16'hBEEF);
        chk("bp_idle_ready", req_ready_a, 1'b1);
        chk("bp_idle_busy", busy_a, 1'b0);

        // Address wrap: 0x0802 and 0x0002 both map to word 1
        txn(1'b1, 16'h0802, 16'h1234, 0, d, w, lat);
        txn(1'b0, 16'h0002, 16'h0000, 0, d, w, lat);
        chk("wrap_rdata", d, 16'h1234);

        // Reset while a store is still waiting: it must never commit
        txn(1'b1, 16'h0020, 16'h5555, 0, d, w, lat);
        @(negedge clk);
        req_valid_a = 1'b1; req_wr_a = 1'b1; req_addr_a = 16'h0020; req_wdata_a = 16'hAAAA;
        @(negedge clk);          // edge 0: accepted
        req_valid_a = 1'b0;
        chk("abort_busy_wait", busy_a, 1'b1);
        @(negedge clk);          // edge 1
        rst = 1'b1;
        @(negedge clk);          // edge 2: reset sampled
        chk("abort_rsp_valid", rsp_valid_a, 1'b0);
        chk("abort_busy", busy_a, 1'b0);
        chk("abort_ready_in_rst", req_ready_a, 1'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        txn(1'b0, 16'h0020, 16'h0000, 0, d, w, lat);
        chk("abort_old_data", d, 16'h5555);

        // LATENCY=1 stream with rsp_ready tied high: one response every 2 cycles
        @(negedge clk);
        j = 0; nresp = 0; last = -1; cyc = 0;
        req_valid_b = 1'b1; req_wr_b = s_wr[0]; req_addr_b = s_addr[0]; req_wdata_b = s_wd[0];
        prev = req_ready_b;
        while ((j < 6 || nresp < 6) && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (prev) begin
                j++;
                if (j < 6) begin
                    req_wr_b = s_wr[j]; req_addr_b = s_addr[j]; req_wdata_b = s_wd[j];
                end else begin
                    req_valid_b = 1'b0;
                end
            end
            if (rsp_valid_b && nresp < 6) begin
                chk($sformatf("l1_rdata_%0d", nresp), rsp_rdata_b, s_exp[nresp]);
                chk($sformatf("l1_rsp_wr_%0d", nresp), rsp_wr_b, s_wr[nresp]);
                if (last >= 0) chk("l1_spacing", cyc - last, 2);
                last = cyc;
                nresp++;
            end
            prev = req_ready_b && req_valid_b;
        end
        chk("l1_count", nresp, 6);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
